// File: rtl/hazard_sequencer.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, branch/jump flushes,
// data-memory freeze with timeout detection, and saturating stall/flush counters.
module hazard_sequencer #(
  parameter int i_size  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [i_size-1:0] id_Instruction,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic              mem_branch_taken,
  input  logic              mem_access,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_flush,
  output logic              ex_flush,
  output logic              ID_flush_lw_stall,
  output logic              ID_flush_branch,
  output logic              pipe_freeze,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              abandon_r;
  logic              mem_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  logic [5:0] opcode_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic       uses_rs_s;
  logic       uses_rt_s;
  logic       lu_s;
  logic       lu_act_s;
  logic       jump_s;
  logic       freeze_s;
  logic       timeout_s;
  logic       unused_s;

  assign opcode_s  = id_Instruction[31:26];
  assign rs_s      = id_Instruction[25:21];
  assign rt_s      = id_Instruction[20:16];
  assign unused_s  = ^id_Instruction[15:0];

  assign uses_rt_s = (opcode_s == 6'd0) || (opcode_s == 6'd2) || (opcode_s == 6'd3);
  assign uses_rs_s = uses_rt_s || (opcode_s == 6'd1);
  assign lu_s      = ex_memread && (ex_rt != 5'd0) &&
                     ((uses_rs_s && (rs_s == ex_rt)) || (uses_rt_s && (rt_s == ex_rt)));
  assign lu_act_s  = lu_s && (state_r == RUN);
  assign jump_s    = (opcode_s == 6'd4);

  // The cycle after a timeout is forced unfrozen so the abandoned access lets the pipe move.
  assign freeze_s  = mem_access && !mem_ready && !abandon_r;
  assign timeout_s = freeze_s && (wait_cnt_r == WAIT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; every state shares the freeze > branch > jump > load-use priority
  always_comb begin
    state_nx_s = RUN;
    case (state_r)
      RUN, LU_STALL, MEM_WAIT: begin
        if (freeze_s && !timeout_s) begin
          state_nx_s = MEM_WAIT;
        end else if (mem_branch_taken || jump_s) begin
          state_nx_s = RUN;
        end else if (lu_act_s) begin
          state_nx_s = LU_STALL;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: state_nx_s = RUN;
    endcase
  end

  // Output decode; everything held low while reset is asserted
  always_comb begin
    pc_write          = 1'b0;
    if_id_write       = 1'b0;
    if_flush          = 1'b0;
    ex_flush          = 1'b0;
    ID_flush_lw_stall = 1'b0;
    ID_flush_branch   = 1'b0;
    pipe_freeze       = 1'b0;
    if (!rst) begin
      pc_write = 1'b0;
    end else if (freeze_s) begin
      pipe_freeze = 1'b1;
    end else if (mem_branch_taken) begin
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      if_flush        = 1'b1;
      ex_flush        = 1'b1;
      ID_flush_branch = 1'b1;
    end else if (jump_s) begin
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      if_flush        = 1'b1;
      ID_flush_branch = 1'b1;
    end else if (lu_act_s) begin
      ID_flush_lw_stall = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  // Memory wait counter, abandon marker and sticky timeout error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      abandon_r  <= 1'b0;
      mem_err_r  <= 1'b0;
    end else begin
      if (freeze_s && !timeout_s) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
      abandon_r <= timeout_s;
      mem_err_r <= mem_err_r | timeout_s;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((ID_flush_lw_stall || pipe_freeze) && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ID_flush_branch && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard controller for the 5-stage core. It sequences PC/IF-ID write enables and the ID-stage flush inputs of the control unit (ID_flush_lw_stall, ID_flush_branch) for four cases:
  - load-use hazards;
  - taken branches resolved in MEM;
  - jumps decoded in ID;
  - multi-cycle data-memory waits.
- Also counts stall and flush cycles and flags memory timeouts.

Parameters:
- i_size, 32, instruction width.
- CNT_W, 16, width of the saturating performance counters.
- TIMEOUT, 64, maximum consecutive memory-wait cycles before error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- id_Instruction  in  i_size  instruction in ID. Fields: opcode [31:26], rs [25:21], rt [20:16].
- ex_memread  in  1  instruction in EX is lw.
- ex_rt  in  5  destination register of the instruction in EX.
- mem_branch_taken  in  1  beq in MEM resolved taken.
- mem_access  in  1  lw or sw in MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_flush  out  1  clear IF/ID to nop.
- ex_flush  out  1  clear ID/EX and EX/MEM (taken branch).
- ID_flush_lw_stall  out  1  to control unit: bubble due to load-use.
- ID_flush_branch  out  1  to control unit: bubble due to branch/jump.
- pipe_freeze  out  1  hold all pipeline registers.
- mem_err  out  1  sticky: memory timeout occurred.
- stall_cnt  out  CNT_W  stall/freeze cycles, saturating.
- flush_cnt  out  CNT_W  flush events, saturating.

Behaviour:
- Reset (rst=0, async):
  - FSM to RUN; wait counter 0; stall_cnt=0, flush_cnt=0, mem_err=0.
  - While rst=0: pc_write=0, if_id_write=0; all flush/freeze outputs 0.
- Opcodes: rtype=0, lw=1, sw=2, beq=3, jump=4.
  - uses_rt = opcode in {0, 2, 3}.
  - uses_rs = opcode in {0, 1, 2, 3}.
- Load-use hazard (lu):
  - lu = ex_memread & ex_rt!=0 & ((uses_rs & rs==ex_rt) | (uses_rt & rt==ex_rt)).
- FSM states:
  - RUN: normal operation.
  - LU_STALL: one bubble has been inserted; lu is ignored in this state.
  - MEM_WAIT: pipeline frozen on a data-memory access.
- Outputs are combinational from state and inputs. Priority order: freeze > branch > jump > load-use.
  - Freeze, when mem_access & !mem_ready and not timed out: pipe_freeze=1, pc_write=0, if_id_write=0, no flushes.
    - Next state MEM_WAIT; wait counter increments.
  - Taken branch (mem_branch_taken, not frozen): pc_write=1, if_flush=1, ex_flush=1, ID_flush_branch=1. Next state RUN.
  - Jump (opcode==4 in ID, no branch): pc_write=1, if_flush=1, ID_flush_branch=1. Next state RUN.
  - Load-use (lu, state RUN, no branch/jump): pc_write=0, if_id_write=0, ID_flush_lw_stall=1. Next state LU_STALL.
  - Default: pc_write=1, if_id_write=1, others 0. Next state RUN.
- LU_STALL lasts exactly one cycle. It returns to RUN unless a freeze or a branch applies.
- MEM_WAIT:
  - Exits on mem_ready=1: that cycle is unfrozen, the counter clears, and the state goes to RUN.
  - Timeout: when the wait counter reaches TIMEOUT-1 with mem_ready still 0:
    - mem_err<=1 (sticky until reset);
    - freeze drops for one cycle, i.e. the access is abandoned;
    - counter clears; state goes to RUN.
- mem_branch_taken arriving during a freeze is held off. It takes effect on the first unfrozen cycle, because the beq remains in MEM.
- Counters, saturating at all-ones:
  - stall_cnt += 1 on each cycle with ID_flush_lw_stall or pipe_freeze.
  - flush_cnt += 1 on each cycle with ID_flush_branch.
- Reset asserted mid-wait or mid-stall aborts immediately to RUN. No outputs glitch to flush on reset release.

Test Plan:
- Load-use:
  - Stimulus: ex_memread=1, ex_rt=5; ID rtype with rs=5. Next cycle ex_memread=0.
  - Required: cycle 0: pc_write=0, if_id_write=0, ID_flush_lw_stall=1. Cycle 1: normal, stall_cnt=1.
- Load-use exceptions:
  - Stimulus 1: ex_rt=0 with rs=0. Stimulus 2: ID lw with rt==ex_rt (rt is its destination).
  - Required: no stall in either case.
- Branch vs load-use:
  - Stimulus: mem_branch_taken=1 together with an lu condition.
  - Required: if_flush=ex_flush=ID_flush_branch=1, pc_write=1, ID_flush_lw_stall=0, flush_cnt=1.
- Jump:
  - Stimulus: opcode=4 in ID.
  - Required: if_flush=1, ID_flush_branch=1, ex_flush=0 for exactly one cycle.
- Memory wait:
  - Stimulus: mem_access=1, mem_ready=0 for 3 cycles, then 1.
  - Required: pipe_freeze=1 for 3 cycles; stall_cnt=3; mem_err=0.
  - Stimulus: TIMEOUT=4 with mem_ready held 0.
  - Required: freeze for 4 cycles, then mem_err=1 and the pipeline resumes. Asserting rst then clears mem_err and both counters.
